// File: rtl/core_csr_counters.sv
// Machine counter CSR file: mcycle, minstret, mhpmcounter3.. and mcountinhibit.
// Combinational reads for decode; write/set/clear from execute; pulses from writeback.
module core_csr_counters #(
  parameter int CNT_WIDTH = 64,
  parameter int NUM_HPM   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               retire_valid,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic [11:0]        rd_addr,
  output logic [31:0]        rd_value,
  output logic               rd_illegal,
  input  logic [1:0]         wr_op,
  input  logic [11:0]        wr_addr,
  input  logic [31:0]        wr_data,
  output logic               wr_illegal
);

  // Counter slots are indexed by the low CSR address bits; slot 1 (time) is absent.
  localparam int NC = NUM_HPM + 3;
  localparam int HW = CNT_WIDTH - 32;
  localparam logic [31:0] INH_MASK =
    32'((64'd1 << NC) - 64'd1) & ~32'd2;

  typedef struct packed {
    logic       ctr;
    logic       inh;
    logic       hi;
    logic [4:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [11:0] a);
    dec_t d;
    d = '0;
    d.idx = a[4:0];
    d.hi  = a[7];
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC)
        && a[6:5] == 2'b00
        && 32'(a[4:0]) < NC
        && a[4:0] != 5'd1)
      d.ctr = 1'b1;
    d.inh = (a == 12'h320);
    return d;
  endfunction

  function automatic logic [31:0] view(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 hi
  );
    logic [63:0] e;
    e = 64'(c);
    return hi ? e[63:32] : e[31:0];
  endfunction

  logic [CNT_WIDTH-1:0] cnt [32];
  logic [31:0]          inh;

  dec_t        rdd;
  dec_t        wdd;
  logic        wr_user;
  logic        wr_ctr;
  logic        wr_legal;
  logic        wr_en;
  logic [31:0] wr_old;
  logic [31:0] wr_new;

  assign rdd = decode(rd_addr);
  assign wdd = decode(wr_addr);

  // Read mux: pre-update register state, zero on illegal addresses.
  always_comb begin
    rd_value   = '0;
    rd_illegal = 1'b1;
    if (rdd.ctr) begin
      rd_value   = view(cnt[rdd.idx], rdd.hi);
      rd_illegal = 1'b0;
    end else if (rdd.inh) begin
      rd_value   = inh;
      rd_illegal = 1'b0;
    end
  end

  assign wr_user  = (wr_addr[11:8] == 4'hC);
  assign wr_ctr   = wdd.ctr && !wr_user;
  assign wr_legal = wr_ctr || wdd.inh;
  assign wr_en    = (wr_op != 2'b00) && wr_legal;
  assign wr_illegal = (wr_op != 2'b00) && !wr_legal;

  // Read-modify-write operand built from the current 32-bit view.
  always_comb begin
    wr_old = wdd.inh ? inh : view(cnt[wdd.idx], wdd.hi);
    wr_new = wr_old;
    unique case (wr_op)
      2'b01:   wr_new = wr_data;
      2'b10:   wr_new = wr_old | wr_data;
      2'b11:   wr_new = wr_old & ~wr_data;
      default: wr_new = wr_old;
    endcase
  end

  // Inhibit register; unimplemented bits are masked on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inh <= '0;
    else if (wr_en && wdd.inh)
      inh <= wr_new & INH_MASK;
  end

  for (genvar k = 0; k < 32; k++) begin : g_ctr
    if (k == 1 || k >= NC) begin : g_none
      assign cnt[k] = '0;
    end else begin : g_cnt
      logic [CNT_WIDTH-1:0] c_q;
      logic                 inc;
      logic                 hit;

      assign hit = wr_en && wr_ctr && (wdd.idx == 5'(k));

      if (k == 0) begin : g_cy
        assign inc = !inh[0];
      end else if (k == 2) begin : g_ir
        assign inc = retire_valid && !inh[2];
      end else begin : g_hpm
        assign inc = hpm_event[k-3] && !inh[k];
      end

      // A write replaces one half and suppresses that cycle's increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          c_q <= '0;
        else if (hit) begin
          if (wdd.hi)
            c_q[CNT_WIDTH-1:32] <= wr_new[HW-1:0];
          else
            c_q[31:0] <= wr_new;
        end else if (inc)
          c_q <= c_q + 1'b1;
      end

      assign cnt[k] = c_q;
    end
  end

endmodule
